// File: rtl/rf_wb_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_pkg: shared types and widths for the register-file writeback arbiter.
//   REG_ADDR_W : register address width
//   XLEN       : data width
//   NUM_REGS   : number of architectural registers (pending vector width)
//   CNT_W      : starve counter width
//   wb_state_e : arbiter FSM states
// -----------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        PIPE_PRI = 2'd0,   // buffer empty, pipeline owns the port
        BUF_WAIT = 2'd1,   // buffer full, pipeline still has priority
        MC_FORCE = 2'd2    // buffer owns the port this cycle
    } wb_state_e;

endpackage : rf_wb_pkg

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard: tracks destinations of in-flight multicycle ops and flags
// decode-stage sources that depend on them. Only built when the arbiter is
// compiled with RF_WB_SCOREBOARD_EN.
// Ports:
//   clk, rst          : clock, async active-high reset
//   i_set, i_set_rd   : op dispatched, mark its destination pending
//   i_clr, i_clr_rd   : result written, clear its destination
//   i_rs1, i_rs2      : decode-stage sources
//   o_hazard          : a nonzero source is pending
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set,
    input  logic [REG_ADDR_W-1:0] i_set_rd,
    input  logic                  i_clr,
    input  logic [REG_ADDR_W-1:0] i_clr_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_hazard
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    // x0 is never marked, so it can never raise a hazard
    assign w_set_mask = (i_set && (i_set_rd != '0)) ? (NUM_REGS'(1) << i_set_rd) : '0;
    assign w_clr_mask = i_clr ? (NUM_REGS'(1) << i_clr_rd) : '0;

    // Clear first, then set: a same-edge issue of the drained rd stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_hazard = ((i_rs1 != '0) && r_pending[i_rs1]) ||
                      ((i_rs2 != '0) && r_pending[i_rs2]);

endmodule : rf_scoreboard

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter: shares the single register-file write port between the
// pipeline writeback stage and a one-entry buffer holding multicycle results.
// The pipeline normally wins; a buffered result that has waited STARVE_MAX
// cycles forces the port for one cycle and stalls the pipeline writeback.
// Optional macro RF_WB_SCOREBOARD_EN adds a pending-destination scoreboard
// driving hazard; without it hazard is tied low.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   wb_valid/wb_rd/wb_data   : pipeline writeback request
//   mc_valid/mc_ready        : multicycle result handshake
//   mc_rd/mc_data            : multicycle destination / data
//   mc_issue/mc_issue_rd     : multicycle op dispatched, with its destination
//   rs1/rs2                  : decode-stage sources
//   RegWrite/rd/WD3          : register file write port
//   wb_stall                 : pipeline writeback held this cycle
//   hazard                   : decode source depends on a pending result
// -----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    input  logic [XLEN-1:0]       mc_data,
    input  logic                  mc_issue,
    input  logic [REG_ADDR_W-1:0] mc_issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       WD3,
    output logic                  wb_stall,
    output logic                  hazard
);

    wb_state_e             r_state;
    logic                  r_buf_valid;
    logic [REG_ADDR_W-1:0] r_buf_rd;
    logic [XLEN-1:0]       r_buf_data;
    logic [CNT_W-1:0]      r_starve_cnt;

    logic                  w_pipe_sel;
    logic                  w_drain;
    logic                  w_capture;
    logic [CNT_W-1:0]      w_cnt_inc;

    // Port selection: pipeline unless the buffer is forcing; x0 writes never reach the port
    assign w_pipe_sel = wb_valid && (wb_rd != '0) && (r_state != MC_FORCE);
    assign w_drain    = !w_pipe_sel && r_buf_valid;
    assign mc_ready   = !r_buf_valid;
    // An mc_rd==0 result completes the handshake but is dropped
    assign w_capture  = mc_valid && mc_ready && (mc_rd != '0);
    assign w_cnt_inc  = r_starve_cnt + CNT_W'(1);

    assign RegWrite = w_pipe_sel || w_drain;
    assign rd       = w_pipe_sel ? wb_rd   : (w_drain ? r_buf_rd   : '0);
    assign WD3      = w_pipe_sel ? wb_data : (w_drain ? r_buf_data : '0);
    assign wb_stall = (r_state == MC_FORCE) && wb_valid && (wb_rd != '0);

    // Buffer, starve counter and arbitration FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PIPE_PRI;
            r_buf_valid  <= 1'b0;
            r_buf_rd     <= '0;
            r_buf_data   <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_buf_valid <= 1'b1;
                r_buf_rd    <= mc_rd;
                r_buf_data  <= mc_data;
            end else if (w_drain) begin
                r_buf_valid <= 1'b0;
            end

            case (r_state)
                PIPE_PRI: begin
                    r_starve_cnt <= '0;
                    if (w_capture) begin
                        r_state <= BUF_WAIT;
                    end
                end
                BUF_WAIT: begin
                    if (w_drain) begin
                        r_starve_cnt <= '0;
                        r_state      <= PIPE_PRI;
                    end else begin
                        if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
                            r_starve_cnt <= w_cnt_inc;
                        end
                        // Counter reaching the limit hands the next cycle to the buffer
                        if (w_cnt_inc == CNT_W'(STARVE_MAX)) begin
                            r_state <= MC_FORCE;
                        end
                    end
                end
                MC_FORCE: begin
                    r_starve_cnt <= '0;
                    r_state      <= PIPE_PRI;
                end
                default: begin
                    r_starve_cnt <= '0;
                    r_state      <= PIPE_PRI;
                end
            endcase
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .i_set    (mc_issue),
        .i_set_rd (mc_issue_rd),
        .i_clr    (w_drain),
        .i_clr_rd (r_buf_rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .o_hazard (hazard)
    );
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{mc_issue, mc_issue_rd, rs1, rs2};
    assign hazard      = 1'b0;
`endif

endmodule : rf_wb_arbiter

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter: directed bench for rf_wb_arbiter (STARVE_MAX = 4).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] WD3;
    logic        wb_stall;
    logic        hazard;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .RegWrite    (RegWrite),
        .rd          (rd),
        .WD3         (WD3),
        .wb_stall    (wb_stall),
        .hazard      (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] r,
                              input logic [31:0] d);
        check({tag, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, we});
        check({tag, ".rd"},       {27'd0, rd},       {27'd0, r});
        check({tag, ".WD3"},      WD3,               d);
    endtask

    task automatic check_ctl(input string tag, input logic rdy, input logic stall,
                             input logic hz);
        check({tag, ".mc_ready"}, {31'd0, mc_ready}, {31'd0, rdy});
        check({tag, ".wb_stall"}, {31'd0, wb_stall}, {31'd0, stall});
        check({tag, ".hazard"},   {31'd0, hazard},   {31'd0, hz});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hAA;
        mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
        mc_issue = 1'b0; mc_issue_rd = '0; rs1 = '0; rs2 = '0;

        // Reset: write port still follows the pipeline, buffer empty
        #1;
        check_port("rst_wb", 1'b1, 5'd3, 32'hAA);
        check_ctl("rst_ctl", 1'b1, 1'b0, 1'b0);
        wb_valid = 1'b0;
        #1;
        check_port("rst_idle", 1'b0, 5'd0, 32'h0);

        step(); rst = 1'b0;

        // Pipeline write alone passes straight through
        step(); wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hAA; #1;
        check_port("wb_only", 1'b1, 5'd3, 32'hAA);
        check_ctl("wb_only", 1'b1, 1'b0, 1'b0);

        // Multicycle result: captured, written one cycle later, ready returns after
        step(); wb_valid = 1'b0; mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h55; #1;
        check_port("mc_offer", 1'b0, 5'd0, 32'h0);
        check_ctl("mc_offer", 1'b1, 1'b0, 1'b0);
        step(); mc_valid = 1'b0; #1;
        check_port("mc_drain", 1'b1, 5'd7, 32'h55);
        check_ctl("mc_drain", 1'b0, 1'b0, 1'b0);
        step(); #1;
        check_port("mc_after", 1'b0, 5'd0, 32'h0);
        check_ctl("mc_after", 1'b1, 1'b0, 1'b0);

        // Starvation: pipeline busy every cycle, buffer forces after 4 waits
        step(); mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h77;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44; #1;
        check_port("st_cap", 1'b1, 5'd4, 32'h44);
        check_ctl("st_cap", 1'b1, 1'b0, 1'b0);
        step(); mc_valid = 1'b0; #1;
        check_port("st_w1", 1'b1, 5'd4, 32'h44);
        check_ctl("st_w1", 1'b0, 1'b0, 1'b0);
        step(); #1;
        check_port("st_w2", 1'b1, 5'd4, 32'h44);
        step(); #1;
        check_port("st_w3", 1'b1, 5'd4, 32'h44);
        step(); #1;
        check_port("st_w4", 1'b1, 5'd4, 32'h44);
        check_ctl("st_w4", 1'b0, 1'b0, 1'b0);
        step(); #1;
        check_port("st_force", 1'b1, 5'd7, 32'h77);
        check_ctl("st_force", 1'b0, 1'b1, 1'b0);
        step(); #1;
        check_port("st_resume", 1'b1, 5'd4, 32'h44);
        check_ctl("st_resume", 1'b1, 1'b0, 1'b0);

        // wb_rd==0 does not claim the port, so the buffer drains
        step(); mc_valid = 1'b1; mc_rd = 5'd12; mc_data = 32'hC0DE; wb_rd = 5'd0; #1;
        check_port("x0_cap", 1'b0, 5'd0, 32'h0);
        step(); mc_valid = 1'b0; #1;
        check_port("x0_drain", 1'b1, 5'd12, 32'hC0DE);
        step(); #1;
        check_port("x0_empty", 1'b0, 5'd0, 32'h0);
        check_ctl("x0_empty", 1'b1, 1'b0, 1'b0);

        // mc_rd==0 is accepted but never written
        wb_valid = 1'b0; mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'hFFFF; #1;
        check_ctl("mc0_offer", 1'b1, 1'b0, 1'b0);
        step(); mc_valid = 1'b0; #1;
        check_port("mc0_c1", 1'b0, 5'd0, 32'h0);
        check_ctl("mc0_c1", 1'b1, 1'b0, 1'b0);
        step(); #1;
        check_port("mc0_c2", 1'b0, 5'd0, 32'h0);

        // Reset while the buffer waits with counter = 2 discards the result
        step(); mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'h5555;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        step(); mc_valid = 1'b0; #1;
        check_ctl("rw_full", 1'b0, 1'b0, 1'b0);
        step();
        step(); #1;
        rst = 1'b1; #1;
        check_port("rw_rst", 1'b1, 5'd4, 32'h44);
        check_ctl("rw_rst", 1'b1, 1'b0, 1'b0);
        wb_valid = 1'b0; #1;
        check_port("rw_rst_idle", 1'b0, 5'd0, 32'h0);
        step(); rst = 1'b0;
        step(); #1;
        check_port("rw_post1", 1'b0, 5'd0, 32'h0);
        check_ctl("rw_post1", 1'b1, 1'b0, 1'b0);
        step(); #1;
        check_port("rw_post2", 1'b0, 5'd0, 32'h0);

`ifdef RF_WB_SCOREBOARD_EN
        // Scoreboard: issue rd=9, hazard visible the next cycle
        step(); mc_issue = 1'b1; mc_issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd0; #1;
        check_ctl("sb_issue", 1'b1, 1'b0, 1'b0);
        step(); mc_issue = 1'b0; #1;
        check_ctl("sb_pend", 1'b1, 1'b0, 1'b1);
        rs1 = 5'd0; rs2 = 5'd9; #1;
        check_ctl("sb_rs2", 1'b1, 1'b0, 1'b1);
        rs1 = 5'd9; rs2 = 5'd0;
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h99;
        step(); mc_valid = 1'b0; mc_issue = 1'b1; mc_issue_rd = 5'd9; #1;
        // Drain of rd=9 and a new issue of rd=9 on the same edge
        check_port("sb_drain1", 1'b1, 5'd9, 32'h99);
        check_ctl("sb_drain1", 1'b0, 1'b0, 1'b1);
        step(); mc_issue = 1'b0; #1;
        check_ctl("sb_setwins", 1'b1, 1'b0, 1'b1);
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h9A;
        step(); mc_valid = 1'b0; #1;
        check_port("sb_drain2", 1'b1, 5'd9, 32'h9A);
        check_ctl("sb_drain2", 1'b0, 1'b0, 1'b1);
        step(); #1;
        check_ctl("sb_clear", 1'b1, 1'b0, 1'b0);
        rs1 = 5'd0; mc_issue = 1'b1; mc_issue_rd = 5'd0;
        step(); mc_issue = 1'b0; #1;
        check_ctl("sb_x0", 1'b1, 1'b0, 1'b0);
`else
        // No scoreboard: hazard stays low even with a matching issue
        step(); mc_issue = 1'b1; mc_issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd9;
        step(); mc_issue = 1'b0; #1;
        check_ctl("nosb_hz", 1'b1, 1'b0, 1'b0);
        step(); #1;
        check_ctl("nosb_hz2", 1'b1, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rf_wb_arbiter
